// File: rtl/pixel_cmd_rx.sv
// Receives 6-bit host symbols on an asynchronous strobe and assembles them into pixel write
// commands, which are queued in a show-ahead FIFO and offered to the SRAM arbiter via req/ack.
module pixel_cmd_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        in_clk,
  input  logic [5:0]  in_data,
  output logic        host_ready,
  output logic        wr_req,
  output logic [7:0]  wr_x,
  output logic [7:0]  wr_y,
  output logic [11:0] wr_rgb,
  input  logic        wr_ack,
  output logic [7:0]  frame_err_cnt,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LOW   = CW'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0] CNT_ALMST = CW'(FIFO_DEPTH - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, S1, S2, S3, S4} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [5:0]             data_sync [SYNC_STAGES];
  logic                   clk_prev;
  logic                   sym_edge;
  logic [5:0]             sym;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_fire, bad_marker, done;
  logic [21:0]     shreg;
  logic [27:0]     cmd;
  logic            pend;

  logic [27:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, push, pop;
  logic [27:0]     head;

  // Strobe synchroniser; in_data rides alongside so the captured symbol matches the edge
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      clk_sync <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], in_clk};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    data_sync[0] <= in_data;
    for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
  end

  assign sym_edge = clk_sync[SYNC_STAGES-1] & ~clk_prev;
  assign sym      = data_sync[SYNC_STAGES-1];

  always_comb begin
    state_nxt  = state;
    tmo_fire   = 1'b0;
    bad_marker = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (sym_edge) begin
        if (sym[5:4] == 2'b01) state_nxt = S1;
        else                   bad_marker = 1'b1;
      end
      S1: if (sym_edge) state_nxt = S2;
      S2: if (sym_edge) state_nxt = S3;
      S3: if (sym_edge) state_nxt = S4;
      S4: if (sym_edge) begin
        state_nxt = IDLE;
        done      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // An edge always wins over an expiring timeout
    if (state != IDLE && !sym_edge && tmo_cnt == TMO_LAST) begin
      state_nxt = IDLE;
      tmo_fire  = 1'b1;
    end
  end

  assign full = (count == CNT_FULL);
  assign pop  = wr_req & wr_ack;
  assign push = pend & (~full | pop);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      frame_err_cnt <= '0;
      pend          <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      host_ready    <= 1'b1;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= (sym_edge || state == IDLE || tmo_fire) ? '0 : tmo_cnt + 1'b1;
      if ((bad_marker || tmo_fire) && frame_err_cnt != 8'hFF)
        frame_err_cnt <= frame_err_cnt + 8'd1;
      pend <= done;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pend && full && !pop) overflow <= 1'b1;
      host_ready <= (count <= CNT_LOW) && !(state == S4 && count == CNT_ALMST);
    end
  end

  // Datapath: symbol shifter, completed command and FIFO storage
  always_ff @(posedge clk) begin
    if (sym_edge) begin
      if (state == IDLE) shreg <= {18'b0, sym[3:0]};
      else               shreg <= {shreg[15:0], sym};
    end
    if (done) cmd <= {shreg, sym};
    if (push) mem[wr_ptr] <= cmd;
  end

  assign wr_req = (count != '0);
  assign head   = mem[rd_ptr];
  assign wr_x   = wr_req ? head[27:20] : 8'd0;
  assign wr_y   = wr_req ? head[19:12] : 8'd0;
  assign wr_rgb = wr_req ? head[11:0]  : 12'd0;

endmodule

// File: tb/tb_pixel_cmd_rx.sv
// Directed bench for pixel_cmd_rx: a queue-based packet/FIFO model checked every cycle,
// plus literal expectations for the decoded commands, error counts and flags.
module tb_pixel_cmd_rx;

  localparam int D  = 4;
  localparam int SS = 2;
  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        in_clk = 1'b0;
  logic [5:0]  in_data = 6'd0;
  logic        wr_ack = 1'b0;
  logic        host_ready, wr_req, overflow;
  logic [7:0]  wr_x, wr_y, frame_err_cnt;
  logic [11:0] wr_rgb;

  pixel_cmd_rx #(.FIFO_DEPTH(D), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_(reset_), .in_clk(in_clk), .in_data(in_data),
    .host_ready(host_ready), .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y),
    .wr_rgb(wr_rgb), .wr_ack(wr_ack), .frame_err_cnt(frame_err_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model state: symbols scheduled by arrival cycle, command queue, packet accumulator
  typedef struct { int t; logic [5:0] s; } ev_t;
  ev_t         eq[$];
  logic [27:0] mq[$];
  logic [27:0] popped[$];
  int          cyc = 0;
  int          nsym = 0;
  int          idle = 0;
  logic [27:0] acc = '0;
  logic [27:0] pcmd = '0;
  bit          pend_m = 0;
  int          err_m = 0;
  bit          ovf_m = 0;
  bit          hr_m = 1;
  bit          chk_en = 0;

  initial forever begin
    @(negedge reset_);
    eq.delete(); mq.delete();
    nsym = 0; idle = 0; pend_m = 0; err_m = 0; ovf_m = 0; hr_m = 1;
  end

  initial begin : model
    int sz;
    bit pop, hr_n;
    ev_t ev;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset_) begin
        sz   = mq.size();
        pop  = (sz != 0) && wr_ack;
        hr_n = (sz <= D - 2) && !(nsym == 4 && sz == D - 1);
        if (pop) void'(mq.pop_front());
        if (pend_m) begin
          if (sz < D || pop) mq.push_back(pcmd);
          else ovf_m = 1;
        end
        pend_m = 0;
        if (eq.size() != 0 && eq[0].t == cyc) begin
          ev = eq.pop_front();
          idle = 0;
          if (nsym == 0) begin
            if (ev.s[5:4] == 2'b01) begin
              acc  = 28'(ev.s[3:0]);
              nsym = 1;
            end else if (err_m < 255) err_m++;
          end else begin
            acc = (acc << 6) | 28'(ev.s);
            nsym++;
            if (nsym == 5) begin
              pend_m = 1;
              pcmd   = acc;
              nsym   = 0;
            end
          end
        end else if (nsym != 0) begin
          idle++;
          if (idle == TO) begin
            nsym = 0;
            idle = 0;
            if (err_m < 255) err_m++;
          end
        end
        hr_m = hr_n;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (reset_ && chk_en) begin
      chk("wr_req", 32'(wr_req), 32'(mq.size() != 0));
      chk("wr_x",   32'(wr_x),   (mq.size() != 0) ? 32'(mq[0][27:20]) : 32'd0);
      chk("wr_y",   32'(wr_y),   (mq.size() != 0) ? 32'(mq[0][19:12]) : 32'd0);
      chk("wr_rgb", 32'(wr_rgb), (mq.size() != 0) ? 32'(mq[0][11:0])  : 32'd0);
      chk("host_ready",    32'(host_ready),    32'(hr_m));
      chk("frame_err_cnt", 32'(frame_err_cnt), 32'(err_m));
      chk("overflow",      32'(overflow),      32'(ovf_m));
      if (wr_req && wr_ack) popped.push_back({wr_x, wr_y, wr_rgb});
    end
  end

  task automatic send_sym(input logic [5:0] s, output int rise);
    repeat (3) @(negedge clk);
    in_data = s;
    in_clk  = 1'b1;
    rise    = cyc;
    eq.push_back('{cyc + SS + 1, s});
    repeat (3) @(negedge clk);
    in_clk = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] x, input logic [7:0] y, input logic [11:0] rgb,
                          input int nsyms, output int last_rise);
    logic [29:0] p;
    p = {2'b01, x, y, rgb};
    for (int i = 0; i < nsyms; i++) send_sym(p[29-6*i -: 6], last_rise);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 reset_ = 1'b0;
    popped.delete();
    repeat (2) @(negedge clk);
    #3 reset_ = 1'b1;
  endtask

  task automatic chk_pop(input string name, input int idx, input logic [27:0] exp);
    if (idx >= popped.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: got no command expected 0x%0h", name, exp);
    end else chk(name, 32'(popped[idx]), 32'(exp));
  endtask

  initial begin : stim
    int r;
    repeat (3) @(negedge clk);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_host_ready", 32'(host_ready), 32'd1);
    chk("rst_err", 32'(frame_err_cnt), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_data", 32'({wr_x, wr_y, wr_rgb}), 32'd0);
    #3 reset_ = 1'b1;
    chk_en = 1;

    // Basic decode with ack held high
    wr_ack = 1'b1;
    send_sym(6'h1A, r); send_sym(6'h2B, r); send_sym(6'h3C, r);
    send_sym(6'h0F, r); send_sym(6'h21, r);
    repeat (10) @(negedge clk);
    chk("t1_req_cycles", 32'(popped.size()), 32'd1);
    chk_pop("t1_cmd", 0, {8'hAA, 8'hFC, 12'h3E1});

    // Bad marker, then a good packet
    do_reset();
    send_sym(6'h3F, r);
    send_pkt(8'h77, 8'h88, 12'h999, 5, r);
    repeat (10) @(negedge clk);
    chk("t2_err", 32'(frame_err_cnt), 32'd1);
    chk_pop("t2_cmd", 0, {8'h77, 8'h88, 12'h999});

    // Partial packet times out
    do_reset();
    send_pkt(8'h12, 8'h34, 12'h567, 3, r);
    repeat (TO + 5) @(negedge clk);
    chk("t3_err", 32'(frame_err_cnt), 32'd1);
    send_pkt(8'h34, 8'h56, 12'h789, 5, r);
    repeat (10) @(negedge clk);
    chk_pop("t3_cmd", 0, {8'h34, 8'h56, 12'h789});

    // Overflow with ack held low
    do_reset();
    wr_ack = 1'b0;
    for (int i = 0; i < 5; i++) send_pkt(8'(8'h10 + i), 8'(8'h60 + i), 12'(12'h100 + i), 5, r);
    repeat (10) @(negedge clk);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_host_ready", 32'(host_ready), 32'd0);
    chk("t4_head_x", 32'(wr_x), 32'h10);
    wr_ack = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_pop_count", 32'(popped.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk_pop("t4_pop", i, {8'(8'h10 + i), 8'(8'h60 + i), 12'(12'h100 + i)});

    // Push and pop in the same cycle while full
    do_reset();
    wr_ack = 1'b0;
    for (int i = 0; i < 4; i++) send_pkt(8'(8'h20 + i), 8'h00, 12'h000, 5, r);
    repeat (10) @(negedge clk);
    send_pkt(8'h24, 8'h00, 12'h000, 5, r);
    for (int n = 0; n < 20 && cyc < r + 3; n++) @(negedge clk);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_overflow", 32'(overflow), 32'd0);
    chk("t5_head_x", 32'(wr_x), 32'h21);
    wr_ack = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_pop_count", 32'(popped.size()), 32'd5);
    chk_pop("t5_last", 4, {8'h24, 8'h00, 12'h000});

    // Reset mid-packet and mid-handshake
    do_reset();
    wr_ack = 1'b0;
    send_pkt(8'h40, 8'h41, 12'h042, 5, r);
    send_pkt(8'h99, 8'h98, 12'h097, 2, r);
    repeat (5) @(negedge clk);
    chk("t6_req_before", 32'(wr_req), 32'd1);
    @(negedge clk);
    #3 reset_ = 1'b0;
    #1;
    chk("t6_rst_req", 32'(wr_req), 32'd0);
    chk("t6_rst_ready", 32'(host_ready), 32'd1);
    chk("t6_rst_data", 32'({wr_x, wr_y, wr_rgb}), 32'd0);
    chk("t6_rst_flags", 32'({overflow, frame_err_cnt}), 32'd0);
    popped.delete();
    repeat (2) @(negedge clk);
    #3 reset_ = 1'b1;
    wr_ack = 1'b1;
    send_pkt(8'h5A, 8'hA5, 12'hABC, 5, r);
    repeat (10) @(negedge clk);
    chk("t6_err", 32'(frame_err_cnt), 32'd0);
    chk_pop("t6_cmd", 0, {8'h5A, 8'hA5, 12'hABC});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
